fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output-side reorder buffer for the 16-point FFT datapath. It captures the 34-bit complex result stream leaving `top`, which arrives in bit-reversed bin order, and replays each 16-sample frame in natural bin order with a valid/ready handshake. It is the consumer-side counterpart of the stimulus stream that feeds `data_in`. It uses a ping-pong pair of 16-entry banks so one frame can fill while the previous one drains.

## Interface
Parameters:
- `N`, 16, points per frame; only 16 is supported.
- `DW`, 34, sample width: `{re[16:0], im[16:0]}`, two's complement.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DW  FFT result sample.
- `in_valid`  in  1  `data_in` valid this cycle.
- `in_ready`  out  1  buffer can accept a sample this cycle.
- `data_out`  out  DW  reordered sample.
- `out_valid`  out  1  `data_out` valid.
- `out_ready`  in  1  downstream accepts `data_out`.
- `out_index`  out  4  natural bin index of `data_out`.
- `out_last`  out  1  high with bin 15 of a frame.
- `overflow`  out  1  sticky flag: a sample was offered while `in_ready` was low.

## Operation
- State:
  - banks `bank0` and `bank1`, each 16×DW registers;
  - `full[1:0]`;
  - `wr_bank` and `wr_ptr[3:0]`;
  - `rd_bank` and `rd_ptr[3:0]`;
  - `overflow`.
- Write side:
  - `in_ready = !full[wr_bank]`.
  - On `in_valid && in_ready`, the sample is stored at `bank[wr_bank][waddr]` and `wr_ptr` increments.
  - When `wr_ptr == 15` on an accepted sample: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_ptr` to 0.
- Write address:
  - With `FFT_REORDER_BITREV_EN`, `waddr = bitrev4(wr_ptr)`, so the 4 bits are mirrored.
  - Without it, `waddr = wr_ptr`.
- Read side:
  - `out_valid = full[rd_bank]`.
  - `data_out = bank[rd_bank][rd_ptr]`, `out_index = rd_ptr`, `out_last = (rd_ptr == 15)`.
  - On `out_valid && out_ready`, `rd_ptr` increments.
  - When `rd_ptr == 15` on a transfer: clear `full[rd_bank]`, toggle `rd_bank`, wrap `rd_ptr` to 0.
- Overflow:
  - `in_valid && !in_ready` sets `overflow`, which stays set until `rst`.
  - The offered sample is dropped and `wr_ptr` does not advance.
- Simultaneous events:
  - Setting `full` on one bank and clearing it on the other in the same cycle are both applied.
  - A set and a clear on the same bank in one cycle cannot occur: a set needs `!full`, a clear needs `full`.
- Datapath: no arithmetic; samples pass bit-exact.

## Timing
- Reset (`rst` high at an edge) forces:
  - `full = 0`, `wr_bank = rd_bank = 0`, `wr_ptr = rd_ptr = 0`, `overflow = 0`.
  - Outputs are then `in_ready = 1`, `out_valid = 0`, `out_last = 0`, `out_index = 0`.
  - `data_out` = contents of bank0 entry 0; the bank contents themselves are not reset.
- Reset mid-frame discards all partial and full frames. The next accepted sample is bin-order sample 0 of a new frame.
- Latency: 16th sample accepted at edge T → `out_valid` high in the cycle following T, with `out_index = 0`.
- Throughput: with `out_ready` held high, 1 sample/cycle in and out continuously, and `in_ready` never drops.
- Both banks full: `in_ready` low until the read side completes bin 15 of the older frame. `in_ready` rises in the cycle after that transfer.
- `out_valid` and `data_out` hold stable while `out_ready` is low.

## Configuration
- `FFT_REORDER_BITREV_EN` defined: write address is bit-reversed, converting bit-reversed FFT output to natural order.
- `FFT_REORDER_BITREV_EN` undefined: write address equals `wr_ptr`, so the block is a pure 2-frame ping-pong buffer with identical handshake and timing.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N = 16`, `FFT_LOG2N = 4`, `SAMPLE_W = 34`, `HALF_W = 17`;
  - typedef `cplx_t` (`re`, `im` fields);
  - function `bitrev4`.
- One sub-module: `fft_pingpong_bank`, the 2×16×DW register array with one write port and one combinational read port. Pointer and flag control stays in `fft_out_reorder`.

## Test plan
- Bit-reverse order (macro on): feed input k = 0..15 as `{re=k, im=0}` back-to-back with `out_ready=1`.
  - `out_valid` rises 1 cycle after input 15 is accepted.
  - Outputs n = 0..15 carry `re` = 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15, with `im = 0`.
  - `out_last` is high only with `re = 15` at `out_index = 15`.
- Passthrough (macro off): same stimulus → output `re = n` at `out_index = n`.
- Streaming: 4 consecutive frames with `out_ready=1` → `in_ready` stays 1, 64 outputs in order, no gaps after the first latency.
- Backpressure/overflow: `out_ready=0`, offer 33 samples.
  - `in_ready` falls after sample 32 is accepted.
  - Sample 33 sets `overflow=1`.
  - Raising `out_ready` drains frame 1 then frame 2 intact; `in_ready` returns to 1 the cycle after frame 1's bin 15 transfer.
- Reset mid-frame: accept 7 samples, assert `rst` for 1 cycle.
  - `out_valid=0`, `in_ready=1`, `overflow=0`.
  - A fresh 16-sample frame then reorders correctly with no stale data.
- Stall hold: toggle `out_ready` every cycle during readout → each `data_out`/`out_index` is held until accepted, and all 16 values appear exactly once.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and bit-reverse helper for the 16-point FFT datapath.
package fft_pkg;
    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;
    localparam int SAMPLE_W  = 34;
    localparam int HALF_W    = 17;

    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } cplx_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction
endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream bundle around the reorder buffer: input side from the FFT core, output side to the consumer.
interface fft_out_reorder_if import fft_pkg::*; #(parameter int DW = SAMPLE_W);
    logic [DW-1:0]        data_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [FFT_LOG2N-1:0] out_index;
    logic                 out_last;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid, out_index, out_last
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid, out_index, out_last
    );
endinterface

// File: rtl/fft_pingpong_bank.sv
// Two banks of N x DW registers: one synchronous write port, one combinational read port.
module fft_pingpong_bank import fft_pkg::*; #(
    parameter int N  = FFT_N,
    parameter int DW = SAMPLE_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 wbank,
    input  logic [FFT_LOG2N-1:0] waddr,
    input  logic [DW-1:0]        wdata,
    input  logic                 rbank,
    input  logic [FFT_LOG2N-1:0] raddr,
    output logic [DW-1:0]        rdata
);
    logic [1:0][N-1:0][DW-1:0] mem;

    // Storage is intentionally not reset; full flags gate its visibility.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        always_ff @(posedge clk) begin
            if (we && (wbank == 1'(b)))
                mem[b][waddr] <= wdata;
        end
    end

    assign rdata = mem[rbank][raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural bin order out.
// Macro FFT_REORDER_BITREV_EN enables bit-reversed write addressing; otherwise plain 2-frame buffer.
module fft_out_reorder import fft_pkg::*; #(
    parameter int N  = FFT_N,
    parameter int DW = SAMPLE_W
) (
    input  logic               clk,
    input  logic               rst,
    fft_out_reorder_if.slave   bus,
    output logic               overflow
);
    localparam logic [FFT_LOG2N-1:0] LAST = FFT_LOG2N'(N - 1);

    logic [1:0]           full, full_nxt;
    logic                 wr_bank, rd_bank;
    logic [FFT_LOG2N-1:0] wr_ptr, rd_ptr, waddr;
    logic                 wr_fire, rd_fire;
    logic [DW-1:0]        rdata;

    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_index = rd_ptr;
    assign bus.out_last  = (rd_ptr == LAST);
    assign bus.data_out  = rdata;

    assign wr_fire = bus.in_valid && !full[wr_bank];
    assign rd_fire = full[rd_bank] && bus.out_ready;

`ifdef FFT_REORDER_BITREV_EN
    assign waddr = bitrev4(wr_ptr);
`else
    assign waddr = wr_ptr;
`endif

    // Set and clear always target different banks, so both may apply in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_ptr == LAST)) full_nxt[wr_bank] = 1'b1;
        if (rd_fire && (rd_ptr == LAST)) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == LAST) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rd_ptr == LAST) rd_bank <= ~rd_bank;
            end
            if (bus.in_valid && full[wr_bank]) overflow <= 1'b1;
        end
    end

    fft_pingpong_bank #(.N(N), .DW(DW)) u_bank (
        .clk   (clk),
        .we    (wr_fire && !rst),
        .wbank (wr_bank),
        .waddr (waddr),
        .wdata (bus.data_in),
        .rbank (rd_bank),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder against a frame-level queue model.
module tb_fft_out_reorder;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;

    fft_out_reorder_if #(.DW(SAMPLE_W)) bus();

    fft_out_reorder #(.N(FFT_N), .DW(SAMPLE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: queue of samples of complete, not yet drained frames in output order.
    logic [SAMPLE_W-1:0] exp_d[$];
    int                  exp_i[$];
    logic [SAMPLE_W-1:0] fbuf[16];
    int                  fcnt = 0;
    bit                  exp_ovf = 0;
    bit                  mon_en = 0;
    bit                  cap_en = 0;
    int                  obs_re[$];

    function automatic int brev(input int k);
        return (k % 2) * 8 + ((k / 2) % 2) * 4 + ((k / 4) % 2) * 2 + (k / 8) % 2;
    endfunction

    function automatic int src_of(input int n);
`ifdef FFT_REORDER_BITREV_EN
        return brev(n);
`else
        return n;
`endif
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            bit rdy_m, vld_m;
            rdy_m = (exp_d.size() <= 16);
            vld_m = (exp_d.size() > 0);
            chk("in_ready", 64'(bus.in_ready), 64'(rdy_m));
            chk("out_valid", 64'(bus.out_valid), 64'(vld_m));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
            if (vld_m) begin
                chk("data_out", 64'(bus.data_out), 64'(exp_d[0]));
                chk("out_index", 64'(bus.out_index), 64'(exp_i[0]));
                chk("out_last", 64'(bus.out_last), 64'(exp_i[0] == 15));
            end
            if (rst) begin
                exp_d.delete();
                exp_i.delete();
                fcnt = 0;
                exp_ovf = 0;
            end else begin
                if (vld_m && bus.out_ready) begin
                    if (cap_en) obs_re.push_back(int'(exp_d[0][33:17]));
                    void'(exp_d.pop_front());
                    void'(exp_i.pop_front());
                end
                if (bus.in_valid && !rdy_m) exp_ovf = 1;
                if (bus.in_valid && rdy_m) begin
                    fbuf[fcnt] = bus.data_in;
                    fcnt++;
                    if (fcnt == 16) begin
                        for (int n = 0; n < 16; n++) begin
                            exp_d.push_back(fbuf[src_of(n)]);
                            exp_i.push_back(n);
                        end
                        fcnt = 0;
                    end
                end
            end
        end
    end

    // 0: hold low, 1: hold high, 2: toggle, 3: random
    int rdy_mode = 1;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b0;
                1: bus.out_ready = 1'b1;
                2: bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Hold one sample until accepted.
    task automatic send(input logic [SAMPLE_W-1:0] d);
        bit ok;
        int t;
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        t = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        if (!ok) chk("send_timeout", 64'(1), 64'(0));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SAMPLE_W-1:0] mk(input int re, input int im);
        cplx_t c;
        c.re = HALF_W'(re);
        c.im = HALF_W'(im);
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl[16];
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
`ifdef FFT_REORDER_BITREV_EN
        tbl = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        for (int n = 0; n < 16; n++) tbl[n] = n;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_out_last", 64'(bus.out_last), 64'(0));
        chk("rst_out_index", 64'(bus.out_index), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed ordering frame.
        rdy_mode = 1;
        cap_en = 1;
        for (int k = 0; k < 16; k++) send(mk(k, 0));
        idle(1);
        wait_drain();
        cap_en = 0;
        chk("order_count", 64'(obs_re.size()), 64'(16));
        for (int n = 0; n < 16 && n < obs_re.size(); n++)
            chk($sformatf("order_re%0d", n), 64'(obs_re[n]), 64'(tbl[n]));

        // Streaming: 4 frames back-to-back.
        for (int k = 0; k < 64; k++) send(SAMPLE_W'({$urandom, $urandom}));
        idle(1);
        wait_drain();

        // Backpressure: 33 offers with out_ready low.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 33; k++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = mk(100 + k, k);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk("bp_overflow", 64'(overflow), 64'(1));
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain();

        // Reset mid-frame.
        for (int k = 0; k < 7; k++) send(mk(200 + k, 1));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("mrst_overflow", 64'(overflow), 64'(0));
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) send(mk(300 + k, -k));
        idle(1);
        wait_drain();

        // Stall hold: toggle out_ready during readout.
        rdy_mode = 0;
        for (int k = 0; k < 16; k++) send(SAMPLE_W'({$urandom, $urandom}));
        idle(2);
        rdy_mode = 2;
        wait_drain();

        // Random traffic.
        rdy_mode = 3;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            bus.data_in  = SAMPLE_W'({$urandom, $urandom});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
